// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready handshake carrying one control word and one datapath word.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 16
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;
  modport master(output valid, ctrl, data, input ready);
  modport slave(input valid, ctrl, data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline boundary register with two-entry skid buffer, flush and bubble-masked control.
module pipe_stage_reg #(
  parameter int                DATA_W      = 16,
  parameter int                CTRL_W      = 8,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int                CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  pipe_stage_reg_if.slave      in_if,
  pipe_stage_reg_if.master     out_if,
  output logic [1:0]           occupancy_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);
  logic              main_v_q, skid_v_q, main_v_d, skid_v_d;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [CNT_W-1:0]  stall_q;
  logic              in_fire, out_fire, ld_main_in, ld_main_skid, ld_skid, stall;
  always_comb begin
    in_fire      = in_if.valid & ~skid_v_q & ~flush_i;
    out_fire     = out_if.valid & out_if.ready;
    ld_main_in   = in_fire & (~main_v_q | out_fire);
    // skid refills main when main drains, and also recovers the unreachable (0,1) state
    ld_main_skid = skid_v_q & ~flush_i & (out_fire | ~main_v_q);
    ld_skid      = in_fire & main_v_q & ~out_fire;
    stall        = out_if.valid & ~out_if.ready;
    main_v_d     = ~flush_i & (ld_main_in | ld_main_skid | (main_v_q & ~out_fire));
    skid_v_d     = ~flush_i & (ld_skid | (skid_v_q & main_v_q & ~out_fire));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_q     <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      if (ld_main_in) begin
        main_ctrl_q <= in_if.ctrl;
        main_data_q <= in_if.data;
      end else if (ld_main_skid) begin
        main_ctrl_q <= skid_ctrl_q;
        main_data_q <= skid_data_q;
      end
      if (ld_skid) begin
        skid_ctrl_q <= in_if.ctrl;
        skid_data_q <= in_if.data;
      end
      if (stall & ~&stall_q) stall_q <= stall_q + 1'b1;
    end
  assign in_if.ready  = ~skid_v_q;
  assign out_if.valid = main_v_q & ~flush_i;
  assign out_if.ctrl  = main_v_q ? main_ctrl_q : CTRL_BUBBLE;
  assign out_if.data  = main_data_q;
  assign occupancy_o  = {1'b0, main_v_q} + {1'b0, skid_v_q};
  assign stall_cnt_o  = stall_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random checks of pipe_stage_reg against a queue-based reference model.
module tb_pipe_stage_reg;
  localparam int DW = 16, CW = 8, NW = 4;
  localparam int SAT = (1 << NW) - 1;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic [1:0] occ;
  logic [NW-1:0] stall;
  int checks = 0, failures = 0;
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) in_if();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) out_if();
  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE('0), .CNT_W(NW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_if(in_if), .out_if(out_if),
    .occupancy_o(occ), .stall_cnt_o(stall)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [CW-1:0] c; logic [DW-1:0] d;} ent_t;
  ent_t q[$];
  int m_cnt = 0;
  logic [DW-1:0] m_last = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_cnt = 0;
    m_last = '0;
  endtask
  // one clock: drive inputs, check pre-edge outputs against the model, then advance the model
  task automatic cycle(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                       input logic ordy, input logic fl);
    bit ev, er;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    ent_t e;
    in_if.valid = iv; in_if.ctrl = ic; in_if.data = id; out_if.ready = ordy; flush = fl;
    #1;
    ev = q.size() > 0 && !fl;
    er = q.size() < 2;
    ec = '0;
    ed = m_last;
    if (q.size() > 0) begin
      ec = q[0].c;
      ed = q[0].d;
    end
    chk("out_valid", 32'(out_if.valid), 32'(ev));
    chk("in_ready", 32'(in_if.ready), 32'(er));
    chk("out_ctrl", 32'(out_if.ctrl), 32'(ec));
    chk("out_data", 32'(out_if.data), 32'(ed));
    chk("occupancy", 32'(occ), 32'(q.size()));
    chk("stall_cnt", 32'(stall), 32'(m_cnt));
    @(posedge clk);
    if (ev && !ordy && m_cnt < SAT) m_cnt++;
    if (fl) q.delete();
    else begin
      if (ev && ordy) e = q.pop_front();
      if (iv && er) q.push_back('{ic, id});
    end
    if (q.size() > 0) m_last = q[0].d;
    @(negedge clk);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    in_if.valid = 1'b1; in_if.ctrl = 8'hFF; in_if.data = 16'hBEEF; out_if.ready = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_if.valid), 0);
    chk("rst_out_ctrl", 32'(out_if.ctrl), 0);
    chk("rst_in_ready", 32'(in_if.ready), 1);
    chk("rst_occupancy", 32'(occ), 0);
    chk("rst_out_data", 32'(out_if.data), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 1; i <= 10; i++) cycle(1'b1, 8'h05, 16'(i), 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 16'h0, 1'b1, 1'b0);
    cycle(1'b1, 8'h11, 16'h0011, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 16'h0022, 1'b0, 1'b0);
    chk("bp_in_ready", 32'(in_if.ready), 0);
    chk("bp_occupancy", 32'(occ), 2);
    cycle(1'b0, 8'h00, 16'h0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 16'h0, 1'b0, 1'b0);
    chk("bp_stall3", 32'(stall), 3);
    cycle(1'b0, 8'h00, 16'h0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 16'h0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 16'h0, 1'b1, 1'b0);
    cycle(1'b1, 8'h44, 16'h0044, 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 16'h0055, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 16'h0033, 1'b1, 1'b1);
    chk("fl_occupancy", 32'(occ), 0);
    chk("fl_out_ctrl", 32'(out_if.ctrl), 0);
    chk("fl_in_ready", 32'(in_if.ready), 1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 16'h0, 1'b1, 1'b0);
    cycle(1'b1, 8'h81, 16'h1234, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 16'h0, 1'b1, 1'b0);
    chk("bub_out_ctrl", 32'(out_if.ctrl), 0);
    chk("bub_out_data", 32'(out_if.data), 32'h1234);
    cycle(1'b0, 8'h00, 16'h0, 1'b1, 1'b0);
    cycle(1'b1, 8'h07, 16'h0777, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 16'h0, 1'b0, 1'b0);
    chk("sat_stall", 32'(stall), SAT);
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(9, 0) < 7, 8'($urandom), 16'($urandom),
            $urandom_range(9, 0) < 6, $urandom_range(19, 0) == 0);
    cycle(1'b1, 8'hA1, 16'hA1A1, 1'b0, 1'b0);
    cycle(1'b1, 8'hA2, 16'hA2A2, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_if.valid), 0);
    chk("arst_occupancy", 32'(occ), 0);
    chk("arst_in_ready", 32'(in_if.ready), 1);
    chk("arst_stall", 32'(stall), 0);
    chk("arst_out_data", 32'(out_if.data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 500; i++)
      cycle($urandom_range(9, 0) < 8, 8'($urandom), 16'($urandom),
            $urandom_range(9, 0) < 5, $urandom_range(29, 0) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
